// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared grid geometry defaults, colour constants and scanner state encoding
package grid_pkg;

  localparam int GRID_W_DEFAULT = 160;
  localparam int GRID_H_DEFAULT = 120;

  localparam logic [2:0] COL_BULLET_DEFAULT = 3'b111;
  localparam logic [2:0] COL_BG_DEFAULT     = 3'b000;
  localparam logic [2:0] COL_PLAYER_DEFAULT = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLOT,
    DONE
  } scan_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_scan_counter.sv
// rtl/grid_scan_counter.sv - column/row scan counters with terminal-count flags
module grid_scan_counter
  import grid_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEFAULT,
  parameter int GRID_H = GRID_H_DEFAULT,
  localparam int CW = cnt_width(GRID_W),
  localparam int RW = cnt_width(GRID_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          row_last
);

  localparam logic [CW-1:0] COL_MAX = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(GRID_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign col_last = (col_q == COL_MAX);
  assign row_last = (row_q == ROW_MAX);

  // Step raster order; the final cell of a frame holds so nothing wraps mid-frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (!col_last) begin
        col_d = col_q + 1'b1;
      end else if (!row_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/grid_scanner.sv
// rtl/grid_scanner.sv - scans a cell grid row by row and emits one pixel write per cell; GRID_SCANNER_PLAYER_EN adds a player overlay
module grid_scanner
  import grid_pkg::*;
#(
  parameter int         GRID_W     = GRID_W_DEFAULT,
  parameter int         GRID_H     = GRID_H_DEFAULT,
  parameter logic [2:0] COL_BULLET = COL_BULLET_DEFAULT,
  parameter logic [2:0] COL_BG     = COL_BG_DEFAULT
`ifdef GRID_SCANNER_PLAYER_EN
  ,
  parameter logic [2:0] COL_PLAYER = COL_PLAYER_DEFAULT
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [6:0]        row_addr,
  input  logic [GRID_W-1:0] row_data,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot,
  input  logic              plot_ready,
  output logic              busy,
  output logic              done
`ifdef GRID_SCANNER_PLAYER_EN
  ,
  input  logic [7:0]        player_x,
  input  logic [6:0]        player_y
`endif
);

  localparam int CW = cnt_width(GRID_W);
  localparam int RW = cnt_width(GRID_H);
  localparam logic [CW-1:0] COL_MAX = CW'(GRID_W - 1);

  scan_state_e       state_q, state_d;
  logic [GRID_W-1:0] row_reg_q, row_reg_d;
  logic [6:0]        row_addr_q, row_addr_d;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          cnt_clear;
  logic          cnt_advance;

  grid_scan_counter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  assign x = 8'(col);
  assign y = 7'(row);

  // The row address follows the counter while fetching and then holds its last value.
  assign row_addr = (state_q == FETCH) ? 7'(row) : row_addr_q;

  // Scan sequencing: fetch a row, load it one cycle later, then plot each cell under handshake.
  always_comb begin
    state_d     = state_q;
    row_reg_d   = row_reg_q;
    row_addr_d  = row_addr_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    plot        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          cnt_clear = 1'b1;
        end
      end
      FETCH: begin
        busy       = 1'b1;
        row_addr_d = 7'(row);
        state_d    = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        row_reg_d = row_data;
        state_d   = PLOT;
      end
      PLOT: begin
        busy = 1'b1;
        plot = 1'b1;
        if (plot_ready) begin
          cnt_advance = 1'b1;
          if (col_last) begin
            state_d = row_last ? DONE : FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel colour: row bit MSB-first maps to column 0; the player cell wins over a bullet.
  always_comb begin
    colour = COL_BG;
    if (state_q == PLOT) begin
      colour = row_reg_q[COL_MAX - col] ? COL_BULLET : COL_BG;
`ifdef GRID_SCANNER_PLAYER_EN
      if ((x == player_x) && (y == player_y)) begin
        colour = COL_PLAYER;
      end
`endif
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      row_reg_q  <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_reg_q  <= row_reg_d;
      row_addr_q <= row_addr_d;
    end
  end

endmodule

// File: tb/tb_grid_scanner.sv
// tb/tb_grid_scanner.sv - directed self-checking bench for grid_scanner; GRID_SCANNER_PLAYER_EN enables the overlay scenario
module tb_grid_scanner;

  logic clock = 1'b0;

  // Free-running clock shared by both scanner instances.
  always #5 clock = ~clock;

  // Small 4x2 instance
  logic       reset;
  logic       start;
  logic       plot_ready;
  logic [3:0] row_data;
  logic [6:0] row_addr;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [3:0] rows [0:1];
`ifdef GRID_SCANNER_PLAYER_EN
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] b_player_x;
  logic [6:0] b_player_y;
`endif

  // Default-size instance
  logic         b_reset;
  logic         b_start;
  logic [159:0] b_row_data;
  logic [6:0]   b_row_addr;
  logic [7:0]   b_x;
  logic [6:0]   b_y;
  logic [2:0]   b_colour;
  logic         b_plot;
  logic         b_busy;
  logic         b_done;

  grid_scanner #(
    .GRID_W (4),
    .GRID_H (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .row_addr   (row_addr),
    .row_data   (row_data),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .plot_ready (plot_ready),
    .busy       (busy),
    .done       (done)
`ifdef GRID_SCANNER_PLAYER_EN
    ,
    .player_x   (player_x),
    .player_y   (player_y)
`endif
  );

  grid_scanner dut_big (
    .clock      (clock),
    .reset      (b_reset),
    .start      (b_start),
    .row_addr   (b_row_addr),
    .row_data   (b_row_data),
    .x          (b_x),
    .y          (b_y),
    .colour     (b_colour),
    .plot       (b_plot),
    .plot_ready (1'b1),
    .busy       (b_busy),
    .done       (b_done)
`ifdef GRID_SCANNER_PLAYER_EN
    ,
    .player_x   (b_player_x),
    .player_y   (b_player_y)
`endif
  );

  // Row memory model: data for row_addr appears one cycle after it is presented.
  always @(posedge clock) row_data <= rows[row_addr[0]];

  int checks = 0;
  int failures = 0;

  logic [7:0] px [0:31];
  logic [6:0] py [0:31];
  logic [2:0] pc [0:31];
  int   n_plot;
  int   n_done;
  int   done_c;
  int   first_plot_c;
  int   stall_seen;
  int   stall_bad;
  logic busy_at_done;
  logic busy_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a frame on the small instance and log every accepted pixel; c=0 is the FETCH cycle.
  task automatic run_frame(input int stall_len, input int restart_c, input int max_c);
    bit fin;
    int stall;
    n_plot       = 0;
    n_done       = 0;
    done_c       = -1;
    first_plot_c = -1;
    stall_seen   = 0;
    stall_bad    = 0;
    busy_at_done = 1'bx;
    busy_after   = 1'b0;
    stall        = stall_len;
    fin          = 1'b0;
    plot_ready   = 1'b1;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < max_c && !fin; c++) begin
      start = (c == restart_c);
      if (plot) begin
        if (first_plot_c < 0) first_plot_c = c;
        if (stall > 0) begin
          plot_ready = 1'b0;
          stall--;
          stall_seen++;
          if (!(x == 8'd0 && y == 7'd0 && colour == 3'd7)) stall_bad++;
        end else begin
          plot_ready = 1'b1;
          if (n_plot < 32) begin
            px[n_plot] = x;
            py[n_plot] = y;
            pc[n_plot] = colour;
          end
          n_plot++;
        end
      end
      if (done_c >= 0 && c > done_c) busy_after = busy_after | busy;
      if (done) begin
        n_done++;
        if (done_c < 0) begin
          done_c       = c;
          busy_at_done = busy;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) fin = 1'b1;
      @(negedge clock);
    end
    start      = 1'b0;
    plot_ready = 1'b1;
  endtask

  int   exp_c1 [0:7] = '{7, 0, 0, 0, 0, 0, 0, 7};
  int   exp_c5 [0:7] = '{7, 0, 0, 0, 0, 0, 0, 2};
  bit   found;
  int   nb;
  int   bad_col;
  int   bdone_c;
  logic [7:0] lx;
  logic [6:0] ly;
  logic bbusy;
  logic prev_busy;
  logic last_busy;

  initial begin
    reset      = 1'b1;
    b_reset    = 1'b1;
    start      = 1'b0;
    b_start    = 1'b0;
    plot_ready = 1'b1;
    b_row_data = '1;
    rows[0]    = 4'b1000;
    rows[1]    = 4'b0001;
`ifdef GRID_SCANNER_PLAYER_EN
    player_x   = 8'd200;
    player_y   = 7'd100;
    b_player_x = 8'hFF;
    b_player_y = 7'h7F;
`endif
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_big_busy", b_busy, 0);
    reset   = 1'b0;
    b_reset = 1'b0;
    @(negedge clock);
    check("idle_busy", busy, 0);

    // Scenario 1: plain frame, plot_ready held high
    run_frame(0, -1, 40);
    check("s1_nplot", n_plot, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s1_x%0d", i), px[i], i % 4);
      check($sformatf("s1_y%0d", i), py[i], i / 4);
      check($sformatf("s1_col%0d", i), pc[i], exp_c1[i]);
    end
    check("s1_first_plot", first_plot_c, 2);
    check("s1_done_c", done_c, 12);
    check("s1_ndone", n_done, 1);
    check("s1_busy_at_done", busy_at_done, 0);
    check("s1_row_addr_hold", row_addr, 1);

    // Scenario 2: stall the first pixel for 5 cycles
    run_frame(5, -1, 60);
    check("s2_stall_seen", stall_seen, 5);
    check("s2_stall_hold", stall_bad, 0);
    check("s2_nplot", n_plot, 8);
    check("s2_x0", px[0], 0);
    check("s2_x1", px[1], 1);
    check("s2_done_c", done_c, 17);

    // Scenario 3: second start during PLOT is ignored
    run_frame(0, 4, 40);
    check("s3_nplot", n_plot, 8);
    check("s3_ndone", n_done, 1);
    check("s3_done_c", done_c, 12);
    check("s3_not_queued", busy_after, 0);

    // Scenario 4: reset mid-frame at (2,0)
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (plot && x == 8'd2 && y == 7'd0) found = 1'b1;
      else @(negedge clock);
    end
    check("s4_reached_2_0", found, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("s4_plot", plot, 0);
    check("s4_busy", busy, 0);
    check("s4_x", x, 0);
    check("s4_y", y, 0);
    repeat (3) @(negedge clock);
    check("s4_not_resumed", busy, 0);
    run_frame(0, -1, 40);
    check("s4_nplot", n_plot, 8);
    check("s4_x0", px[0], 0);
    check("s4_y0", py[0], 0);
    check("s4_done_c", done_c, 12);

`ifdef GRID_SCANNER_PLAYER_EN
    // Scenario 5: player overlay at (3,1)
    player_x = 8'd3;
    player_y = 7'd1;
    run_frame(0, -1, 40);
    check("s5_nplot", n_plot, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s5_col%0d", i), pc[i], exp_c5[i]);
    end
    player_x = 8'd200;
    player_y = 7'd100;
`endif

    // Scenario 6: default-size grid, all cells occupied
    nb        = 0;
    bad_col   = 0;
    bdone_c   = -1;
    lx        = '0;
    ly        = '0;
    bbusy     = 1'bx;
    prev_busy = 1'bx;
    last_busy = 1'b0;
    found     = 1'b0;
    b_start   = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    for (int c = 0; c < 25000 && !found; c++) begin
      if (b_plot) begin
        nb++;
        if (b_colour !== 3'd7) bad_col++;
        lx = b_x;
        ly = b_y;
      end
      if (b_done) begin
        bdone_c   = c;
        bbusy     = b_busy;
        prev_busy = last_busy;
        found     = 1'b1;
      end else begin
        last_busy = b_busy;
        @(negedge clock);
      end
    end
    check("s6_nplot", nb, 19200);
    check("s6_bad_colour", bad_col, 0);
    check("s6_last_x", lx, 159);
    check("s6_last_y", ly, 119);
    check("s6_done_c", bdone_c, 19440);
    check("s6_busy_at_done", bbusy, 0);
    check("s6_busy_before_done", prev_busy, 1);
    check("s6_row_addr_hold", b_row_addr, 119);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
